loom_clk_ctrl: RTL

Run/stop/step controller for the emulated design's gated clock. It accepts host commands over a valid/ready port, sequences a registered clock-enable (free-run, halt, or exactly N cycles), and halts on a breakpoint request from the design. It keeps a count of delivered gated edges, reports the halt cause, and instantiates the glitch-free clock gating cell that produces the design clock.

---
 rtl/loom_clk_ctrl_pkg.sv | 29 ++
 rtl/loom_clk_gate.sv | 19 +
 rtl/loom_clk_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/loom_clk_ctrl_pkg.sv
// loom_clk_ctrl_pkg: shared opcodes, halt causes and controller states
// for the emulation clock controller.
package loom_clk_ctrl_pkg;

    localparam int OpW    = 3;
    localparam int CauseW = 2;

    typedef enum logic [OpW-1:0] {
        OP_NOP  = 3'd0,
        OP_RUN  = 3'd1,
        OP_STOP = 3'd2,
        OP_STEP = 3'd3,
        OP_CLR  = 3'd4
    } op_e;

    typedef enum logic [CauseW-1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_HOST  = 2'd1,
        CAUSE_STEP  = 2'd2,
        CAUSE_BREAK = 2'd3
    } cause_e;

    typedef enum logic [1:0] {
        ST_HALTED = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2
    } state_e;

endpackage

// File: rtl/loom_clk_gate.sv
// loom_clk_gate: latch-based glitch-free clock gate; the enable is
// captured while clk_in is low so clk_out never produces a runt pulse.
module loom_clk_gate (
    input  logic clk_in,
    input  logic ce,
    output logic clk_out
);

    logic en_l;

    always_latch begin
        if (!clk_in) begin
            en_l = ce;
        end
    end

    assign clk_out = clk_in & en_l;

endmodule

// File: rtl/loom_clk_ctrl.sv
// loom_clk_ctrl: run/stop/step sequencer for the emulated design clock,
// with breakpoint halt, halt-cause reporting and a gated-edge counter.
module loom_clk_ctrl
    import loom_clk_ctrl_pkg::*;
#(
    parameter int StepW  = 32,
    parameter int CycleW = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [OpW-1:0]    cmd_op_i,
    input  logic [StepW-1:0]  cmd_arg_i,
    input  logic              stop_req_i,
    output logic              clk_gated_o,
    output logic              ce_o,
    output logic              running_o,
    output logic              done_o,
    output logic              cmd_err_o,
    output logic [CauseW-1:0] halt_cause_o,
    output logic [StepW-1:0]  step_left_o,
    output logic [CycleW-1:0] cycle_cnt_o
);

    state_e             state_q, state_d;
    cause_e             cause_q, cause_d;
    logic [StepW-1:0]   left_q, left_d;
    logic [CycleW-1:0]  cnt_q, cnt_d;
    logic               ce_q;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic is_run, is_stop, is_step, is_clr, illegal;

    assign is_run  = cmd_valid_i && (cmd_op_i == OP_RUN);
    assign is_stop = cmd_valid_i && (cmd_op_i == OP_STOP);
    assign is_step = cmd_valid_i && (cmd_op_i == OP_STEP);
    assign is_clr  = cmd_valid_i && (cmd_op_i == OP_CLR);
    assign illegal = cmd_valid_i && (cmd_op_i > OP_CLR);

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        left_d  = left_q;
        done_d  = 1'b0;
        err_d   = illegal || (is_step && (state_q != ST_HALTED));
        cnt_d   = cnt_q + CycleW'(ce_q);
        if (is_clr) begin
            cnt_d = '0;
        end

        unique case (state_q)
            ST_HALTED: begin
                if (is_run) begin
                    state_d = ST_RUN;
                end else if (is_step && (cmd_arg_i != '0)) begin
                    state_d = ST_STEP;
                    left_d  = cmd_arg_i;
                end else if (is_step) begin
                    done_d  = 1'b1;
                    cause_d = CAUSE_STEP;
                end
            end
            ST_RUN: begin
                if (stop_req_i) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_BREAK;
                end else if (is_stop) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_HOST;
                end
            end
            ST_STEP: begin
                // Every STEP cycle delivers an edge, so the count always moves.
                left_d = left_q - StepW'(1);
                if (stop_req_i) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_BREAK;
                end else if (is_stop) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_HOST;
                    left_d  = '0;
                end else if (is_run) begin
                    state_d = ST_RUN;
                    left_d  = '0;
                end else if (left_q == StepW'(1)) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_STEP;
                end
            end
            default: begin
                state_d = ST_HALTED;
            end
        endcase

        if ((state_q != ST_HALTED) && (state_d == ST_HALTED)) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_HALTED;
            cause_q <= CAUSE_NONE;
            left_q  <= '0;
            cnt_q   <= '0;
            ce_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            left_q  <= left_d;
            cnt_q   <= cnt_d;
            ce_q    <= (state_d != ST_HALTED);
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready_o  = 1'b1;
    assign ce_o         = ce_q;
    assign running_o    = (state_q != ST_HALTED);
    assign done_o       = done_q;
    assign cmd_err_o    = err_q;
    assign halt_cause_o = cause_q;
    assign step_left_o  = left_q;
    assign cycle_cnt_o  = cnt_q;

    loom_clk_gate u_gate (
        .clk_in  (clk_i),
        .ce      (ce_q),
        .clk_out (clk_gated_o)
    );

endmodule
